// File: rtl/array_scan.sv
`default_nettype none
// ============================================================================
// array_scan : walks index_o over an array, streams entries on valid/ready.
// Optional build macro ARRAY_SCAN_LOOP_EN: repeat frames until stop_i is seen.
// Rev 1.0
// ============================================================================
module array_scan #(
  parameter int width_p  = 8,
  parameter int height_p = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
`ifdef ARRAY_SCAN_LOOP_EN
  input  logic                        stop_i,
`endif
  output logic                        busy_o,
  output logic                        done_o,
  output logic [$clog2(height_p)-1:0] index_o,
  input  logic [width_p-1:0]          rd_data_i,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  output logic                        last_o,
  input  logic                        ready_i
);

  localparam int                 c_ptr_w    = $clog2(height_p);
  localparam logic [c_ptr_w-1:0] c_last_idx = c_ptr_w'(height_p - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_ptr_w-1:0]   r_ptr;
  logic [c_ptr_w-1:0]   w_ptr_nxt;
  logic                 r_v;
  logic                 r_last;
  logic                 r_done;
  logic [width_p-1:0]   r_data;
  logic                 w_load;
  logic                 w_accept;
  logic                 w_at_last;
  logic                 w_wrap;

  assign w_accept  = r_v & ready_i;
  assign w_load    = (r_state == SCAN) & (~r_v | ready_i);
  assign w_at_last = (r_ptr == c_last_idx);

`ifdef ARRAY_SCAN_LOOP_EN
  logic r_stop;

  // A stop raised in the same cycle as the frame-end load still ends the scan.
  assign w_wrap = w_at_last & ~(r_stop | stop_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_stop <= 1'b0;
    end else if ((r_state != IDLE) && (w_state_nxt == IDLE)) begin
      r_stop <= 1'b0;
    end else if ((r_state != IDLE) && stop_i) begin
      r_stop <= 1'b1;
    end
  end
`else
  assign w_wrap = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = SCAN;
          w_ptr_nxt   = '0;
        end
      end
      SCAN: begin
        if (w_load) begin
          // Explicit wrap so non-power-of-two heights never overrun.
          if (w_at_last) begin
            w_ptr_nxt = '0;
            if (!w_wrap) begin
              w_state_nxt = DRAIN;
            end
          end else begin
            w_ptr_nxt = r_ptr + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (w_accept) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_done  <= (r_state == DRAIN) & w_accept;
    end
  end

  // Single-entry output register; holds steady while downstream stalls.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v    <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (w_load) begin
      r_v    <= 1'b1;
      r_data <= rd_data_i;
      r_last <= w_at_last;
    end else if (w_accept) begin
      r_v    <= 1'b0;
    end
  end

  assign busy_o  = (r_state == SCAN) | (r_state == DRAIN);
  assign done_o  = r_done;
  assign index_o = r_ptr;
  assign v_o     = r_v;
  assign data_o  = r_data;
  assign last_o  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_array_scan.sv
`default_nettype none
// ============================================================================
// tb_array_scan : randomized and directed bench for array_scan against a
// transaction-level model of the scan. Rev 1.0
// ============================================================================
module tb_array_scan;

  localparam int H = 4;
  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         ready;
  logic         busy;
  logic         done;
  logic [1:0]   index;
  logic [W-1:0] rd_data;
  logic         v;
  logic [W-1:0] data;
  logic         last;
  logic [W-1:0] mem [H];

`ifdef ARRAY_SCAN_LOOP_EN
  logic stop;
  initial stop = 1'b1;
`endif

  assign rd_data = mem[index];

  array_scan #(.width_p(W), .height_p(H)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .start_i   (start),
`ifdef ARRAY_SCAN_LOOP_EN
    .stop_i    (stop),
`endif
    .busy_o    (busy),
    .done_o    (done),
    .index_o   (index),
    .rd_data_i (rd_data),
    .v_o       (v),
    .data_o    (data),
    .last_o    (last),
    .ready_i   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a scan is "loaded entries so far" plus one output slot.
  int           m_loaded;
  bit           m_scan;
  bit           m_v;
  logic [W-1:0] m_data;
  bit           m_last;
  bit           m_done;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_loaded <= 0;
      m_scan   <= 1'b0;
      m_v      <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      m_done   <= 1'b0;
    end else begin
      m_done <= m_scan && (m_loaded == H) && m_v && ready;
      if (!m_scan) begin
        if (start) begin
          m_scan   <= 1'b1;
          m_loaded <= 0;
        end
      end else if ((m_loaded < H) && (!m_v || ready)) begin
        m_v      <= 1'b1;
        m_data   <= mem[m_loaded[1:0]];
        m_last   <= (m_loaded == H - 1);
        m_loaded <= m_loaded + 1;
      end else if (m_v && ready) begin
        m_v <= 1'b0;
        if (m_loaded == H) m_scan <= 1'b0;
      end
    end
  end

  int n_beats;
  int n_done;
  initial begin
    n_beats = 0;
    n_done  = 0;
  end
  always @(posedge clk) begin
    if (reset_n && v && ready) n_beats <= n_beats + 1;
    if (reset_n && done)       n_done  <= n_done + 1;
  end

  int checks;
  int failures;
  bit cmp_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare DUT against the model mid-cycle, then leave room to drive.
  task automatic cyc();
    int exp_idx;
    @(negedge clk);
    if (cmp_en) begin
      exp_idx = (m_scan && m_loaded < H) ? m_loaded : 0;
      check("busy", busy, m_scan);
      check("v", v, m_v);
      check("done", done, m_done);
      check("index", index, exp_idx);
      if (m_v) begin
        check("data", data, m_data);
        check("last", last, m_last);
      end
    end
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] exp1 [H];
  int           beats0;
  int           done0;
  bit           rpat [6];

  initial begin
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    exp1     = '{8'h11, 8'h22, 8'h33, 8'h44};
    rpat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    mem      = '{8'h11, 8'h22, 8'h33, 8'h44};
    start    = 1'b0;
    ready    = 1'b1;
    reset_n  = 1'b0;
    idle(3);
    check("reset_v", v, 0);
    check("reset_busy", busy, 0);
    check("reset_data", data, 0);
    check("reset_index", index, 0);
    check("reset_last", last, 0);
    check("reset_done", done, 0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    idle(2);

    // Full scan at full rate with literal expectations.
    start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      if (k == 1) start = 1'b0;
      check("t1_v", v, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) begin
        check("t1_data", data, exp1[k-2]);
        check("t1_last", last, (k == 5));
      end
      check("t1_done", done, (k == 6));
    end
    check("t1_busy_after", busy, 0);
    idle(2);

    // Backpressure pattern: same four beats, one done.
    beats0 = n_beats;
    done0  = n_done;
    start  = 1'b1;
    for (int k = 0; k < 24; k++) begin
      ready = rpat[k % 6];
      cyc();
      start = 1'b0;
    end
    ready = 1'b1;
    idle(2);
    check("t2_beats", n_beats - beats0, 4);
    check("t2_dones", n_done - done0, 1);

    // Second start mid-scan is ignored.
    beats0 = n_beats;
    done0  = n_done;
    start  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      start = (k == 3);
    end
    start = 1'b0;
    idle(2);
    check("t3_beats", n_beats - beats0, 4);
    check("t3_dones", n_done - done0, 1);

    // Reset after 0x22 accepted: async clear, no done, fresh scan restarts.
    done0 = n_done;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("t4_async_v", v, 0);
    check("t4_async_data", data, 0);
    check("t4_async_busy", busy, 0);
    check("t4_async_index", index, 0);
    check("t4_async_last", last, 0);
    cyc();
    reset_n = 1'b1;
    idle(6);
    check("t4_no_done", n_done - done0, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check("t4_first_v", v, 1);
    check("t4_first_data", data, 8'h11);
    idle(6);

    // Write to entry 3 while ptr==1: final beat carries the new value.
    start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      start = 1'b0;
      if (k == 2) begin
        check("t5_ptr1", index, 1);
        mem[3] = 8'hAA;
      end
      if (k == 5) begin
        check("t5_data", data, 8'hAA);
        check("t5_last", last, 1);
      end
    end
    idle(2);

    // Randomized traffic: backpressure, starts, writes, occasional reset.
    for (int k = 0; k < 600; k++) begin
      ready = ($urandom_range(0, 99) < 65);
      start = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) < 25) mem[$urandom_range(0, H-1)] = W'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
      end else begin
        cyc();
      end
    end
    start = 1'b0;
    ready = 1'b1;
    idle(10);
    check("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
